// File: rtl/ofdm_output_serializer.sv
// rtl/ofdm_output_serializer.sv - wide-to-narrow OFDM output serializer with one-entry holding register
module ofdm_output_serializer #(
  parameter  int IN_WIDTH   = 304,
  parameter  int OUT_WIDTH  = 16,
  parameter  bit MSB_FIRST  = 1'b0,
  localparam int NUM_CHUNKS = IN_WIDTH / OUT_WIDTH,
  localparam int CW         = $clog2(NUM_CHUNKS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [CW-1:0]        in_chunks,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 done
);

  localparam logic [CW-1:0] MAX_LEN = CW'(NUM_CHUNKS);

  // Active symbol being drained, plus a one-deep holding slot for the next one
  logic [IN_WIDTH-1:0]  r_act;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_len;
  logic                 r_busy;
  logic [IN_WIDTH-1:0]  r_hold_data;
  logic [CW-1:0]        r_hold_len;
  logic                 r_hold_full;
  logic                 r_done;

  logic                 w_in_acc;
  logic                 w_out_acc;
  logic                 w_last;
  logic                 w_last_acc;
  logic [CW-1:0]        w_in_len;
  logic [OUT_WIDTH-1:0] w_beat;
  logic [IN_WIDTH-1:0]  w_act_shifted;

  // in_ready comes straight from a flop so upstream sees no combinational path
  assign in_ready   = !r_hold_full;
  assign w_in_acc   = in_valid && !r_hold_full;
  assign w_out_acc  = r_busy && out_ready;
  assign w_last     = r_busy && (r_cnt == (r_len - CW'(1)));
  assign w_last_acc = w_out_acc && w_last;

  // Out-of-range lengths (0 or too large) mean a full symbol
  assign w_in_len = ((in_chunks == '0) || (in_chunks > MAX_LEN)) ? MAX_LEN : in_chunks;

  // Beat order is fixed at elaboration: low chunk first, or top chunk first
  assign w_beat        = MSB_FIRST ? r_act[IN_WIDTH-1 -: OUT_WIDTH] : r_act[OUT_WIDTH-1:0];
  assign w_act_shifted = MSB_FIRST ? (r_act << OUT_WIDTH) : (r_act >> OUT_WIDTH);

  assign out_valid = r_busy;
  assign out_data  = r_busy ? w_beat : '0;
  assign out_last  = w_last;
  assign done      = r_done;

  // Load/shift/hold sequencing; a final-beat accept reloads from HOLD first, then from the input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_act       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_busy      <= 1'b0;
      r_hold_data <= '0;
      r_hold_len  <= '0;
      r_hold_full <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_acc;
      if (!r_busy) begin
        if (w_in_acc) begin
          r_act  <= in_data;
          r_len  <= w_in_len;
          r_cnt  <= '0;
          r_busy <= 1'b1;
        end
      end else if (w_last_acc) begin
        if (r_hold_full) begin
          // in_ready is low this cycle, so no input can collide with the reload
          r_act       <= r_hold_data;
          r_len       <= r_hold_len;
          r_cnt       <= '0;
          r_hold_full <= 1'b0;
        end else if (w_in_acc) begin
          r_act <= in_data;
          r_len <= w_in_len;
          r_cnt <= '0;
        end else begin
          r_busy <= 1'b0;
        end
      end else begin
        if (w_out_acc) begin
          r_act <= w_act_shifted;
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_in_acc) begin
          r_hold_data <= in_data;
          r_hold_len  <= w_in_len;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofdm_output_serializer.sv
// tb/tb_ofdm_output_serializer.sv - directed self-checking bench for ofdm_output_serializer
module tb_ofdm_output_serializer;

  localparam int IW = 304;
  localparam int OW = 16;
  localparam int NC = 19;
  localparam int CW = 5;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic [CW-1:0] in_chunks;
  logic          out_ready;

  logic          in_ready,  in_ready_m;
  logic [OW-1:0] out_data,  out_data_m;
  logic          out_valid, out_valid_m;
  logic          out_last,  out_last_m;
  logic          done,      done_m;

  ofdm_output_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chunks(in_chunks), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  ofdm_output_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .in_chunks(in_chunks), .out_data(out_data_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m), .done(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [IW-1:0] make_sym(input logic [15:0] base);
    logic [IW-1:0] s;
    s = '0;
    for (int k = 0; k < NC; k++) s[16*k +: 16] = base + 16'(k);
    return s;
  endfunction

  typedef struct {
    logic [OW-1:0] lsb;
    logic [OW-1:0] msb;
    logic          last;
  } beat_t;

  beat_t q[$];
  logic  mon_en = 1'b0;
  logic  m_busy = 1'b0;
  logic  m_hold = 1'b0;
  logic  m_done = 1'b0;
  int    done_cnt = 0;
  int    run_len  = 0;
  int    last_run = 0;

  // Reference model: tracks busy/hold occupancy and the expected beat stream
  always @(negedge clk) begin
    if (mon_en) begin
      logic acc_in, acc_out, lacc;
      int   n;
      beat_t b;
      check("in_ready",   in_ready,   !m_hold);
      check("in_ready_m", in_ready_m, !m_hold);
      check("out_valid",  out_valid,  m_busy);
      check("out_valid_m", out_valid_m, m_busy);
      if (m_busy && q.size() > 0) begin
        check("beat_lsb", out_data,   q[0].lsb);
        check("beat_msb", out_data_m, q[0].msb);
        check("last_lsb", out_last,   q[0].last);
        check("last_msb", out_last_m, q[0].last);
      end else begin
        check("idle_data",   out_data,   16'h0);
        check("idle_data_m", out_data_m, 16'h0);
        check("idle_last",   out_last,   1'b0);
      end
      if (m_done || done || done_m) begin
        check("done",   done,   m_done);
        check("done_m", done_m, m_done);
      end
      if (done) done_cnt++;
      if (out_valid) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
      if (!reset_n) begin
        q.delete();
        m_busy = 1'b0;
        m_hold = 1'b0;
        m_done = 1'b0;
      end else begin
        acc_in  = in_valid && !m_hold;
        acc_out = m_busy && out_ready && (q.size() > 0);
        lacc    = acc_out && q[0].last;
        m_done  = lacc;
        if (acc_out) void'(q.pop_front());
        if (acc_in) begin
          n = ((in_chunks == 0) || (in_chunks > NC)) ? NC : int'(in_chunks);
          for (int j = 0; j < n; j++) begin
            b.lsb  = in_data[16*j +: 16];
            b.msb  = in_data[16*(NC-1-j) +: 16];
            b.last = (j == n - 1);
            q.push_back(b);
          end
        end
        if (!m_busy) begin
          if (acc_in) m_busy = 1'b1;
        end else if (lacc) begin
          if (m_hold) m_hold = 1'b0;
          else if (!acc_in) m_busy = 1'b0;
        end else if (acc_in) begin
          m_hold = 1'b1;
        end
      end
    end
  end

  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  int         bp_ph   = 0;

  // Downstream ready: constant high, or the 1,0,0,1 backpressure pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = bp_pat[bp_ph];
        bp_ph = (bp_ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic [CW-1:0] n);
    in_valid  = 1'b1;
    in_data   = d;
    in_chunks = n;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!m_busy && q.size() == 0) break;
    end
    if (i == 400) check("drain_timeout", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int d0;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chunks = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  16'h0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_done",      done,      1'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk);
    #1;

    // Single full symbol, beats 0x0000..0x0012 (reversed on the MSB-first instance)
    d0 = done_cnt;
    send(make_sym(16'h0000), 5'd19);
    in_valid = 1'b0;
    check("t1_first_lsb", out_data,   16'h0000);
    check("t1_first_msb", out_data_m, 16'h0012);
    wait_idle();
    check("t1_run",  last_run, 19);
    check("t1_done", done_cnt - d0, 1);

    // Backpressure with input overwritten after accept
    d0 = done_cnt;
    bp_mode = 1'b1;
    send(make_sym(16'h0040), 5'd19);
    in_valid = 1'b0;
    in_data  = '1;
    wait_idle();
    bp_mode = 1'b0;
    check("t2_done", done_cnt - d0, 1);

    // Back-to-back A, B, C
    d0 = done_cnt;
    send(make_sym(16'h0100), 5'd19);
    send(make_sym(16'h0200), 5'd19);
    send(make_sym(16'h0300), 5'd19);
    in_valid = 1'b0;
    wait_idle();
    check("t3_run",  last_run, 57);
    check("t3_done", done_cnt - d0, 3);

    // Length handling: 3, 0 -> 19, 25 -> 19
    d0 = done_cnt;
    send(make_sym(16'h0500), 5'd3);
    in_valid = 1'b0;
    wait_idle();
    check("t4a_run",  last_run, 3);
    check("t4a_done", done_cnt - d0, 1);
    d0 = done_cnt;
    send(make_sym(16'h0600), 5'd0);
    in_valid = 1'b0;
    wait_idle();
    check("t4b_run",  last_run, 19);
    check("t4b_done", done_cnt - d0, 1);
    d0 = done_cnt;
    send(make_sym(16'h0700), 5'd25);
    in_valid = 1'b0;
    wait_idle();
    check("t4c_run",  last_run, 19);
    check("t4c_done", done_cnt - d0, 1);

    // Reset mid-symbol with HOLD occupied
    d0 = done_cnt;
    send(make_sym(16'h0800), 5'd19);
    send(make_sym(16'h0900), 5'd19);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_hold_full", in_ready, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_out_data",  out_data,  16'h0);
    check("t5_in_ready",  in_ready,  1'b1);
    check("t5_done",      done,      1'b0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send(make_sym(16'h0A00), 5'd19);
    in_valid = 1'b0;
    check("t5_first_lsb", out_data, 16'h0A00);
    wait_idle();
    check("t5_run",  last_run, 19);
    check("t5_done2", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
